// File: rtl/puzzle_stage_ctrl_pkg.sv
// Shared types and level constants for the puzzle stage controller.
// Zone origins below describe the current level's default trigger layout.
package puzzle_pkg;

    typedef enum logic [1:0] {
        REDRAW   = 2'd0,
        STABLE   = 2'd1,
        ANIM     = 2'd2,
        FINISHED = 2'd3
    } stageState_t;

    localparam int unsigned ZONE0_X = 120;
    localparam int unsigned ZONE0_Y = 156;
    localparam int unsigned ZONE1_X = 189;
    localparam int unsigned ZONE1_Y = 151;
    localparam int unsigned ZONE2_X = 177;
    localparam int unsigned ZONE2_Y = 213;
    localparam int unsigned ZONE3_X = 122;
    localparam int unsigned ZONE3_Y = 156;

    localparam int unsigned FIN_X_MIN_DEF = 156;
    localparam int unsigned FIN_Y_MAX_DEF = 55;

endpackage

// File: rtl/puzzle_stage_ctrl_zone_hit.sv
// Single square trigger-zone comparator.
// Bounds are widened by one bit so a zone near the coordinate limit cannot wrap.
module zone_hit #(
    parameter int unsigned X_W     = 9,
    parameter int unsigned Y_W     = 8,
    parameter int unsigned ZONE_SZ = 6
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [X_W-1:0] zoneX,
    input  logic [Y_W-1:0] zoneY,
    output logic           hit
);

    logic [X_W:0] xWide, xLo, xHi;
    logic [Y_W:0] yWide, yLo, yHi;

    always_comb begin
        xWide = {1'b0, x};
        yWide = {1'b0, y};
        xLo   = {1'b0, zoneX};
        yLo   = {1'b0, zoneY};
        xHi   = xLo + (X_W+1)'(ZONE_SZ - 1);
        yHi   = yLo + (Y_W+1)'(ZONE_SZ - 1);
        hit   = (xWide >= xLo) && (xWide <= xHi) && (yWide >= yLo) && (yWide <= yHi);
    end

endmodule

// File: rtl/puzzle_stage_ctrl.sv
// Puzzle stage tracker: sequences redraw/animation handshakes and flags completion.
// Optional redraw watchdog is enabled by defining REDRAW_WATCHDOG_EN.
module puzzle_stage_ctrl
    import puzzle_pkg::*;
#(
    parameter int unsigned              NUM_STAGES  = 4,
    parameter int unsigned              X_W         = 9,
    parameter int unsigned              Y_W         = 8,
    parameter int unsigned              ZONE_SZ     = 6,
    parameter logic [NUM_STAGES-1:0]    ANIM_MASK   = 4'b1000,
    parameter int unsigned              FIN_X_MIN   = FIN_X_MIN_DEF,
    parameter int unsigned              FIN_Y_MAX   = FIN_Y_MAX_DEF,
    parameter int unsigned              TIMEOUT_CYC = 1048575
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic [X_W-1:0]                    x,
    input  logic [Y_W-1:0]                    y,
    input  logic                              activate,
    input  logic [NUM_STAGES*X_W-1:0]         zone_x,
    input  logic [NUM_STAGES*Y_W-1:0]         zone_y,
    input  logic                              done_redraw,
    input  logic                              done_animation,
    output logic [$clog2(NUM_STAGES+1)-1:0]   stage,
    output logic                              draw_map,
    output logic                              start_animation,
    output logic                              game_done,
    output logic                              redraw_timeout
);

    localparam int unsigned SW = $clog2(NUM_STAGES + 1);

    stageState_t   state, stateNext;
    logic [SW-1:0] stageNext;
    logic          armed, armedNext;

    logic [X_W-1:0] fwdZoneX, bwdZoneX;
    logic [Y_W-1:0] fwdZoneY, bwdZoneY;
    logic           animFwd, fwdHit, bwdHit;
    logic           canFwd, canBwd, atFinish, press;
    logic           wdExpire;

    // Select the forward (stage) and backward (stage-1) zone origins
    always_comb begin
        fwdZoneX = '0;
        fwdZoneY = '0;
        bwdZoneX = '0;
        bwdZoneY = '0;
        animFwd  = 1'b0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (SW'(k) == stage) begin
                fwdZoneX = zone_x[k*X_W +: X_W];
                fwdZoneY = zone_y[k*Y_W +: Y_W];
                animFwd  = ANIM_MASK[k];
            end
            if (SW'(k + 1) == stage) begin
                bwdZoneX = zone_x[k*X_W +: X_W];
                bwdZoneY = zone_y[k*Y_W +: Y_W];
            end
        end
    end

    zone_hit #(.X_W(X_W), .Y_W(Y_W), .ZONE_SZ(ZONE_SZ)) fwdZone (
        .x     (x),
        .y     (y),
        .zoneX (fwdZoneX),
        .zoneY (fwdZoneY),
        .hit   (fwdHit)
    );

    zone_hit #(.X_W(X_W), .Y_W(Y_W), .ZONE_SZ(ZONE_SZ)) bwdZone (
        .x     (x),
        .y     (y),
        .zoneX (bwdZoneX),
        .zoneY (bwdZoneY),
        .hit   (bwdHit)
    );

    always_comb begin
        press    = activate && armed;
        canFwd   = (stage < SW'(NUM_STAGES)) && fwdHit;
        canBwd   = (stage != '0) && bwdHit;
        atFinish = (stage == SW'(NUM_STAGES)) && (x >= X_W'(FIN_X_MIN)) && (y <= Y_W'(FIN_Y_MAX));
    end

    always_comb begin
        stateNext       = state;
        stageNext       = stage;
        armedNext       = armed;
        draw_map        = 1'b0;
        start_animation = 1'b0;
        game_done       = 1'b0;
        case (state)
            REDRAW: begin
                draw_map = 1'b1;
                if ((done_redraw || wdExpire) && !activate) begin
                    stateNext = STABLE;
                end
            end
            STABLE: begin
                if (!activate) begin
                    armedNext = 1'b1;
                end
                if (atFinish) begin
                    stateNext = FINISHED;
                end else if (canFwd && press) begin
                    armedNext = 1'b0;
                    if (animFwd) begin
                        stateNext = ANIM;
                    end else begin
                        stageNext = stage + 1'b1;
                        stateNext = REDRAW;
                    end
                end else if (canBwd && press) begin
                    armedNext = 1'b0;
                    stageNext = stage - 1'b1;
                    stateNext = REDRAW;
                end
            end
            ANIM: begin
                draw_map        = 1'b1;
                start_animation = 1'b1;
                if (done_animation || wdExpire) begin
                    stageNext = stage + 1'b1;
                    stateNext = REDRAW;
                end
            end
            FINISHED: begin
                draw_map  = 1'b1;
                game_done = 1'b1;
            end
            default: stateNext = REDRAW;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= REDRAW;
            stage <= '0;
            armed <= 1'b0;
        end else begin
            state <= stateNext;
            stage <= stageNext;
            armed <= armedNext;
        end
    end

`ifdef REDRAW_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wdCount;
    logic            timeoutFlag;
    logic            wdActive;

    always_comb begin
        wdActive = (state == REDRAW) || (state == ANIM);
        wdExpire = wdActive && (wdCount == WD_W'(TIMEOUT_CYC - 1));
    end

    // Counter saturates at the limit so a REDRAW held by activate keeps expiring
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wdCount     <= '0;
            timeoutFlag <= 1'b0;
        end else begin
            if (!wdActive || (stateNext != state)) begin
                wdCount <= '0;
            end else if (!wdExpire) begin
                wdCount <= wdCount + 1'b1;
            end
            if (wdExpire && (stateNext != state)) begin
                timeoutFlag <= 1'b1;
            end
        end
    end

    assign redraw_timeout = timeoutFlag;
`else
    assign wdExpire       = 1'b0;
    assign redraw_timeout = 1'b0;
`endif

endmodule

// File: doc/puzzle_stage_ctrl.md
Name: puzzle_stage_ctrl

Overview:
- Parametrised successor to the fixed game-state FSM. Tracks the puzzle stage (0..NUM_STAGES) from sprite position plus activation presses.
- Sequences map redraws and animations through handshakes, and flags game completion.
- Sits between sprite controller (X/Y, activate) and map drawer/animator (draw_map, start_animation, done_redraw, done_animation).

Parameters:
- NUM_STAGES, 4, number of forward transitions; stages 0..NUM_STAGES.
- X_W, 9, sprite X width.
- Y_W, 8, sprite Y width.
- ZONE_SZ, 6, trigger zone edge length in pixels; zone is [zx, zx+ZONE_SZ-1] x [zy, zy+ZONE_SZ-1].
- ANIM_MASK, 4'b1000, bit k=1: forward transition k->k+1 plays an animation before redraw.
- FIN_X_MIN, 156, finish region X lower bound (inclusive).
- FIN_Y_MAX, 55, finish region Y upper bound (inclusive).
- TIMEOUT_CYC, 1048575, redraw watchdog limit (optional feature only).

Ports:
- clock  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- x  in  X_W  sprite X.
- y  in  Y_W  sprite Y.
- activate  in  1  level-sensitive key press.
- zone_x  in  NUM_STAGES*X_W  zone k origin X at bits [k*X_W +: X_W]; static.
- zone_y  in  NUM_STAGES*Y_W  zone k origin Y; static.
- done_redraw  in  1  drawer finished full map pass.
- done_animation  in  1  animator finished.
- stage  out  SW=$clog2(NUM_STAGES+1)  current committed stage.
- draw_map  out  1  request map redraw for current stage.
- start_animation  out  1  animation request (level).
- game_done  out  1  finish reached; sticky until reset.
- redraw_timeout  out  1  sticky watchdog flag (optional feature only; tied 0 otherwise).

Behaviour:
- States: REDRAW, STABLE, ANIM, FINISHED. Registered on posedge clock.
- Reset: state=REDRAW, stage=0, armed=0, all outputs 0 except draw_map=1 (Moore, from REDRAW).
- Reset mid-operation aborts any redraw/animation the next cycle.
- in_zone(k): zone_x[k] <= x <= zone_x[k]+ZONE_SZ-1 and same for y, compared at X_W+1 / Y_W+1 bits so no wrap.
- armed: set when state==STABLE and activate==0; cleared on every accepted transition. Only armed presses are accepted, so one hold = one transition.
- REDRAW: draw_map=1. Go to STABLE when done_redraw && !activate; otherwise hold.
- STABLE: draw_map=0.
  - Forward: stage<NUM_STAGES && in_zone(stage) && activate && armed.
    - ANIM_MASK[stage]=1: go to ANIM.
    - Otherwise stage<=stage+1 and go to REDRAW.
  - Backward: stage>0 && in_zone(stage-1) && activate && armed -> stage<=stage-1, go to REDRAW. Backward never animates.
  - Forward has priority when both zones match.
  - Finish: stage==NUM_STAGES && x>=FIN_X_MIN && y<=FIN_Y_MAX -> FINISHED. Needs no activate; has priority over backward.
- ANIM: start_animation=1, draw_map=1. On done_animation: stage<=stage+1, go to REDRAW.
- FINISHED: draw_map=1, game_done=1. Absorbing until reset.
- Stage never exceeds NUM_STAGES and never underflows.
- Outputs are Moore, decoded from registered state; one-cycle latency from a qualifying input to an output change.

Optional Feature:
- Macro REDRAW_WATCHDOG_EN.
- Defined: a counter runs in REDRAW and ANIM, clearing on entry. At TIMEOUT_CYC it forces the state exit as if the done input arrived (activate still required low for REDRAW), and sets sticky redraw_timeout.
- Undefined: no counter; redraw_timeout tied 0; the block waits indefinitely.

Decomposition:
- Package puzzle_pkg holds:
  - state enum (REDRAW=0, STABLE=1, ANIM=2, FINISHED=3);
  - default zone table constants for the current level (120/156, 189/151, 177/213, 122/156);
  - finish bounds.
- Sub-module zone_hit: parametrised single-zone comparator, instantiated twice (forward and backward zone).

Test Plan:
- Reset, done_redraw=1, activate=0 -> draw_map 1 then 0 next cycle; stage=0, state STABLE.
- x=122,y=158, activate held 20 cycles -> exactly one transition; stage=1 after redraw handshake; no second advance until release and re-press.
- Stage 1, sprite in zone 0 (120,156) with activate -> stage returns to 0 via REDRAW. Overlapping forward/backward zones -> forward wins.
- Stage 3 with ANIM_MASK[3]=1, press in zone 3 -> start_animation=1 until done_animation; then stage=4, draw_map=1.
- Stage 4, x=160,y=50 with no activate -> game_done=1 next cycle and sticky. resetn=0 -> stage 0, game_done 0.
- With REDRAW_WATCHDOG_EN, TIMEOUT_CYC=16, done_redraw stuck 0 -> STABLE after 16 cycles, redraw_timeout=1.
